// File: rtl/uart_pkg.sv
// Shared types and decode helpers for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  function automatic logic [3:0] nbits_f(input logic [1:0] cfg_bits);
    return 4'd5 + {2'b00, cfg_bits};
  endfunction

  // Keeps only the bits that belong to the selected character width.
  function automatic logic [7:0] data_mask_f(input logic [1:0] cfg_bits);
    case (cfg_bits)
      2'd0:    return 8'h1F;
      2'd1:    return 8'h3F;
      2'd2:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and first-word-fall-through read.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q;
  logic             push, pop;

  // Both flags come from registers, so a same-cycle pop never frees a slot for a write.
  assign push = wr_en_i && !full_q;
  assign pop  = rd_en_i && !empty_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
      empty_q <= (level_d == '0);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/tx_uart_cfg.sv
// UART transmitter with input FIFO and per-frame selectable data width, parity and stop bits.
module tx_uart_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    cfg_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic                          tx_started,
  output logic                          tx_done
);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             stop2_q, stop2_d;
  logic             stop_idx_q, stop_idx_d;

  logic       fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rd_data, load_data;
  logic       bit_end, load;

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (in_valid),
    .wr_data_i (in_data),
    .rd_en_i   (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign in_ready  = !fifo_full;
  assign bit_end   = (cnt_q == '0);
  assign load_data = fifo_rd_data & data_mask_f(cfg_bits);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_idx_d = stop_idx_q;
    load       = 1'b0;
    fifo_pop   = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? div_q : cnt_q - DIV_W'(1);
    end

    case (state_q)
      IDLE: load = !fifo_empty;
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_idx_q == stop2_q) begin
            state_d = IDLE;
            load    = !fifo_empty;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame settings are captured only here, so mid-frame input changes wait for the next frame.
    if (load) begin
      fifo_pop  = 1'b1;
      state_d   = START;
      cnt_d     = baud_div;
      div_d     = baud_div;
      shift_d   = load_data;
      nbits_d   = nbits_f(cfg_bits);
      par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      par_bit_d = (^load_data) ^ (cfg_parity == PAR_ODD);
      stop2_d   = cfg_stop2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  always_comb begin
    tx_pin = 1'b1;
    case (state_q)
      START:   tx_pin = 1'b0;
      DATA:    tx_pin = shift_q[0];
      PARITY:  tx_pin = par_bit_q;
      default: tx_pin = 1'b1;
    endcase
  end

  assign tx_busy    = (state_q != IDLE);
  assign tx_started = (state_q == START) && (cnt_q == div_q);
  assign tx_done    = (state_q == STOP) && bit_end && (stop_idx_q == stop2_q);

endmodule

// File: tb/tb_tx_uart_cfg.sv
// Randomized bench for tx_uart_cfg against a queue-based frame/waveform model.
module tb_tx_uart_cfg;

  localparam int DEPTH = 16;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [DIV_W-1:0] baud_div = 16'd4;
  logic [1:0]       cfg_bits = 2'd3;
  logic [1:0]       cfg_parity = 2'd0;
  logic             cfg_stop2 = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic [4:0]       fifo_level;
  logic             tx_pin, tx_busy, tx_started, tx_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  bit         m_wave[$];
  bit         m_fresh = 1'b0;

  tx_uart_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div   (baud_div),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_level (fifo_level),
    .tx_pin     (tx_pin),
    .tx_busy    (tx_busy),
    .tx_started (tx_started),
    .tx_done    (tx_done)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected line level per clock for one whole frame, built from the frame-format rules.
  task automatic build_frame(input logic [7:0] d);
    bit bits[$];
    bit par;
    int nb;
    nb  = 5 + int'(cfg_bits);
    par = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      par ^= d[i];
    end
    if (cfg_parity == 2'd1) bits.push_back(par);
    if (cfg_parity == 2'd2) bits.push_back(!par);
    bits.push_back(1'b1);
    if (cfg_stop2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k <= int'(baud_div); k++) m_wave.push_back(bits[i]);
    end
  endtask

  task automatic model_step();
    bit acc;
    acc = in_valid && (m_q.size() < DEPTH);
    m_fresh = 1'b0;
    if (m_wave.size() > 0) void'(m_wave.pop_front());
    if (m_wave.size() == 0 && m_q.size() > 0) begin
      build_frame(m_q.pop_front());
      m_fresh = 1'b1;
    end
    if (acc) m_q.push_back(in_data);
  endtask

  task automatic check_cycle();
    bit exp_pin;
    exp_pin = (m_wave.size() > 0) ? m_wave[0] : 1'b1;
    check_val("tx_pin",     tx_pin,     exp_pin);
    check_val("tx_busy",    tx_busy,    m_wave.size() > 0);
    check_val("tx_started", tx_started, m_fresh);
    check_val("tx_done",    tx_done,    m_wave.size() == 1);
    check_val("in_ready",   in_ready,   m_q.size() < DEPTH);
    check_val("fifo_level", fifo_level, m_q.size());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_tx_pin",  tx_pin,     1);
    check_val("rst_busy",    tx_busy,    0);
    check_val("rst_started", tx_started, 0);
    check_val("rst_done",    tx_done,    0);
    check_val("rst_ready",   in_ready,   1);
    check_val("rst_level",   fifo_level, 0);
    m_q.delete();
    m_wave.delete();
    m_fresh = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] b, input logic [1:0] p, input logic s2,
                         input logic [DIV_W-1:0] dv);
    cfg_bits   = b;
    cfg_parity = p;
    cfg_stop2  = s2;
    baud_div   = dv;
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while ((m_wave.size() > 0 || m_q.size() > 0) && k < limit) begin
      cycle();
      k++;
    end
    check_val("idle_timeout", (k < limit), 1);
    run(3);
  endtask

  initial begin
    do_reset();
    run(3);

    set_cfg(2'd3, 2'd0, 1'b0, 16'd4);
    send(8'hA5);
    wait_idle(200);

    set_cfg(2'd2, 2'd1, 1'b1, 16'd4);
    send(8'h53);
    wait_idle(200);

    set_cfg(2'd0, 2'd2, 1'b0, 16'd4);
    send(8'hFF);
    wait_idle(200);

    // Burst larger than the FIFO while a frame is already on the wire.
    set_cfg(2'd3, 2'd0, 1'b0, 16'd4);
    send(8'h11);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    wait_idle(2000);

    send(8'h3C);
    send(8'hC3);
    run(12);
    set_cfg(2'd1, 2'd1, 1'b0, 16'd2);
    wait_idle(400);

    // Reset in the middle of the data bits with more bytes queued.
    set_cfg(2'd3, 2'd0, 1'b0, 16'd4);
    send(8'h96);
    send(8'h69);
    send(8'h5A);
    run(15);
    do_reset();
    run(60);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0)
        set_cfg(2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom_range(0, 3)));
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    wait_idle(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
